// File: rtl/dac_stream_formatter.sv
// rtl/dac_stream_formatter.sv - two-lane DAC sample formatter with offset/saturation, routing and soft-mute gain ramp
// Output is a two-stage stream pipeline; every register advances only when the output register can move.
module dac_stream_formatter #(
   parameter int DW   = 14,
   parameter int STEP = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] ch_a,
   input  logic [DW-1:0] ch_b,
   input  logic [DW-1:0] offset_a,
   input  logic [DW-1:0] offset_b,
   input  logic [1:0]    mode,
   input  logic          enable,
   output logic [31:0]   m_axis_tdata,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic [1:0]    ramp_state
);

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      ACTIVE    = 2'd2,
      RAMP_DOWN = 2'd3
   } ramp_t;

   localparam logic [9:0] STEP_W    = 10'(STEP);
   localparam logic [8:0] GAIN_FULL = 9'd256;

   logic [DW-1:0] s1_l0_q, s1_l0_d;
   logic [DW-1:0] s1_l1_q, s1_l1_d;
   logic          v1_q, v1_d;
   logic [31:0]   tdata_q, tdata_d;
   logic          tvalid_q, tvalid_d;
   logic [8:0]    gain_q, gain_d;
   ramp_t         state_q, state_d;
   logic [DW-1:0] tcnt_q, tcnt_d;

   logic          adv;
   logic [DW-1:0] sat_a, sat_b;
   logic [9:0]    gain_up_raw;
   logic [8:0]    gain_up, gain_dn;
   logic [15:0]   lane0_ext, lane1_ext;

   // Overflow of the DW+1 bit sum shows up as disagreeing top two bits.
   function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] ch, input logic [DW-1:0] off);
      logic [DW:0] sum;
      sum = {ch[DW-1], ch} + {off[DW-1], off};
      if (sum[DW] != sum[DW-1])
         return sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      return sum[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] scale(input logic [DW-1:0] s, input logic [8:0] g);
      logic signed [DW+9:0] a;
      logic signed [DW+9:0] b;
      logic signed [DW+9:0] prod;
      logic signed [DW+9:0] sh;
      a    = {{10{s[DW-1]}}, s};
      b    = {{(DW+1){1'b0}}, g};
      prod = a * b;
      sh   = prod >>> 8;
      return sh[DW-1:0];
   endfunction

   assign adv         = !tvalid_q || m_axis_tready;
   assign sat_a       = sat_add(ch_a, offset_a);
   assign sat_b       = sat_add(ch_b, offset_b);
   assign gain_up_raw = {1'b0, gain_q} + STEP_W;
   assign gain_up     = (gain_up_raw > {1'b0, GAIN_FULL}) ? GAIN_FULL : gain_up_raw[8:0];
   assign gain_dn     = ({1'b0, gain_q} <= STEP_W) ? 9'd0 : (gain_q - STEP_W[8:0]);

   always_comb begin
      s1_l0_d   = s1_l0_q;
      s1_l1_d   = s1_l1_q;
      v1_d      = v1_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      gain_d    = gain_q;
      state_d   = state_q;
      tcnt_d    = tcnt_q;
      lane0_ext = '0;
      lane1_ext = '0;
      lane0_ext[DW-1:0] = scale(s1_l0_q, gain_q);
      lane1_ext[DW-1:0] = scale(s1_l1_q, gain_q);

      if (adv) begin
         case (mode)
            2'd0: begin s1_l0_d = sat_a;  s1_l1_d = sat_b;  end
            2'd1: begin s1_l0_d = sat_b;  s1_l1_d = sat_a;  end
            2'd2: begin s1_l0_d = sat_a;  s1_l1_d = sat_a;  end
            default: begin s1_l0_d = tcnt_q; s1_l1_d = tcnt_q; end
         endcase

         v1_d     = 1'b1;
         tvalid_d = v1_q;
         // gain_q was updated on the same edge as the stage-1 data it scales here.
         tdata_d  = {lane1_ext, lane0_ext};

         if (tvalid_q && m_axis_tready && (mode == 2'd3))
            tcnt_d = tcnt_q + 1'b1;

         // Direction follows enable in every state; the endpoints decide MUTED/ACTIVE.
         gain_d = enable ? gain_up : gain_dn;
         if (gain_d == GAIN_FULL)
            state_d = ACTIVE;
         else if (gain_d == 9'd0)
            state_d = MUTED;
         else
            state_d = enable ? RAMP_UP : RAMP_DOWN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_l0_q  <= '0;
         s1_l1_q  <= '0;
         v1_q     <= 1'b0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         gain_q   <= '0;
         state_q  <= MUTED;
         tcnt_q   <= '0;
      end else begin
         s1_l0_q  <= s1_l0_d;
         s1_l1_q  <= s1_l1_d;
         v1_q     <= v1_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         gain_q   <= gain_d;
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign ramp_state    = state_q;

endmodule

// File: tb/tb_dac_stream_formatter.sv
// tb/tb_dac_stream_formatter.sv - directed vector bench for dac_stream_formatter
module tb_dac_stream_formatter;

   localparam int DW   = 14;
   localparam int STEP = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] ch_a = '0;
   logic [DW-1:0] ch_b = '0;
   logic [DW-1:0] offset_a = '0;
   logic [DW-1:0] offset_b = '0;
   logic [1:0]    mode = 2'd0;
   logic          enable = 1'b0;
   logic [31:0]   m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic [1:0]    ramp_state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      int          mode;
      int          a;
      int          b;
      int          oa;
      int          ob;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[6];

   int          exp_l0[5];
   int          exp_st[5];

   dac_stream_formatter #(.DW(DW), .STEP(STEP)) dut (
      .clk           (clk),
      .rst           (rst),
      .ch_a          (ch_a),
      .ch_b          (ch_b),
      .offset_a      (offset_a),
      .offset_b      (offset_b),
      .mode          (mode),
      .enable        (enable),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .ramp_state    (ramp_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{"normal_offset", 0,   100,  -100,  5,  -5, 32'h3F97_0069};
      vecs[1] = '{"saturate",      0,  8000, -8000, 500, -500, 32'h2000_1FFF};
      vecs[2] = '{"swap",          1,   100,   200,  1,   2, 32'h0065_00CA};
      vecs[3] = '{"dup_a_sat",     2, -8192,     5, -1,   0, 32'h2000_2000};
      vecs[4] = '{"edge_nosat",    0,  8190, -8191,  1,   1, 32'h2002_1FFF};
      vecs[5] = '{"neg_one",       0,     0,    -1,  0,   0, 32'h3FFF_0000};
      exp_l0  = '{0, 250, 500, 750, 1000};
      exp_st  = '{1, 1, 1, 2, 2};

      // reset state and valid start-up
      step();
      step();
      chk("rst_tdata", m_axis_tdata, 32'h0);
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_state", 32'(ramp_state), 32'd0);
      rst = 1'b0;
      step();
      chk("start_tvalid_1", 32'(m_axis_tvalid), 32'd0);
      step();
      chk("start_tvalid_2", 32'(m_axis_tvalid), 32'd1);

      // ramp-up
      ch_a   = 14'd1000;
      enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("rampup_lane0_%0d", k), 32'(m_axis_tdata[15:0]), 32'(exp_l0[k]));
         chk($sformatf("rampup_state_%0d", k), 32'(ramp_state), 32'(exp_st[k]));
      end

      // routing and saturation at full gain
      for (int i = 0; i < 6; i++) begin
         mode     = 2'(vecs[i].mode);
         ch_a     = 14'(vecs[i].a);
         ch_b     = 14'(vecs[i].b);
         offset_a = 14'(vecs[i].oa);
         offset_b = 14'(vecs[i].ob);
         step();
         step();
         chk(vecs[i].name, m_axis_tdata, vecs[i].exp);
      end

      // ramp reversal and flooring
      mode = 2'd0; ch_a = 14'h3FFF; ch_b = '0; offset_a = '0; offset_b = '0;
      enable = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("down_to_muted", 32'(ramp_state), 32'd0);
      enable = 1'b1;
      step();
      step();
      step();
      chk("rev_up_state", 32'(ramp_state), 32'd1);
      enable = 1'b0;
      step();
      chk("rev_state_e4", 32'(ramp_state), 32'd3);
      step();
      chk("rev_state_e5", 32'(ramp_state), 32'd3);
      chk("floor_lane0", 32'(m_axis_tdata[15:0]), 32'h3FFF);
      chk("floor_lane1", 32'(m_axis_tdata[31:16]), 32'h0);
      step();
      chk("rev_muted", 32'(ramp_state), 32'd0);
      step();
      chk("rev_zero_lane0", 32'(m_axis_tdata[15:0]), 32'h0);

      // backpressure
      enable = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("bp_active", 32'(ramp_state), 32'd2);
      ch_a = 14'd10;
      step();
      ch_a = 14'd20;
      step();
      chk("bp_before", 32'(m_axis_tdata[15:0]), 32'd10);
      ch_a = 14'd30;
      m_axis_tready = 1'b0;
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp_hold_data_%0d", i), 32'(m_axis_tdata[15:0]), 32'd10);
         chk($sformatf("bp_hold_state_%0d", i), 32'(ramp_state), 32'd2);
         chk($sformatf("bp_hold_valid_%0d", i), 32'(m_axis_tvalid), 32'd1);
         ch_a = 14'(40 + 10 * i);
      end
      m_axis_tready = 1'b1;
      enable = 1'b1;
      ch_a = 14'd80;
      step();
      chk("bp_resume_1", 32'(m_axis_tdata[15:0]), 32'd20);
      step();
      chk("bp_resume_2", 32'(m_axis_tdata[15:0]), 32'd80);

      // test ramp with backpressure, then counter wrap
      mode = 2'd3;
      step();
      step();
      chk("tm_0", m_axis_tdata, 32'h0000_0000);
      m_axis_tready = 1'b0;
      step();
      chk("tm_hold", m_axis_tdata, 32'h0000_0000);
      m_axis_tready = 1'b1;
      step();
      chk("tm_1", m_axis_tdata, 32'h0001_0001);
      step();
      chk("tm_2", m_axis_tdata, 32'h0002_0002);
      for (int i = 0; i < 16381; i++) step();
      chk("tm_max", m_axis_tdata, 32'h3FFF_3FFF);
      step();
      chk("tm_wrap", m_axis_tdata, 32'h0000_0000);

      // reset during RAMP_DOWN
      mode = 2'd0; ch_a = 14'd1000; enable = 1'b0;
      step();
      chk("pre_rst_state", 32'(ramp_state), 32'd3);
      chk("pre_rst_valid", 32'(m_axis_tvalid), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(m_axis_tvalid), 32'd0);
      chk("async_rst_tdata", m_axis_tdata, 32'h0);
      chk("async_rst_state", 32'(ramp_state), 32'd0);
      step();
      chk("held_rst_state", 32'(ramp_state), 32'd0);
      rst = 1'b0;
      step();
      chk("post_rst_valid_1", 32'(m_axis_tvalid), 32'd0);
      step();
      chk("post_rst_valid_2", 32'(m_axis_tvalid), 32'd1);
      chk("post_rst_tdata", m_axis_tdata, 32'h0);
      chk("post_rst_state", 32'(ramp_state), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_stream_formatter.md
DAC_STREAM_FORMATTER -- requirements
Module: dac_stream_formatter

Interface
REQ-001 SHALL have parameter DW, default 14: sample width per lane, legal range 8..16.
REQ-002 SHALL have parameter STEP, default 64: gain increment/decrement per advancing cycle, legal range 1..256.
REQ-003 SHALL have port clk, input, 1 bit: clock (125 MHz domain).
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port ch_a, input, DW bits: signed two's-complement sample for lane 0.
REQ-006 SHALL have port ch_b, input, DW bits: signed sample for lane 1.
REQ-007 SHALL have ports offset_a and offset_b, input, DW bits each: signed per-lane offsets.
REQ-008 SHALL have port mode, input, 2 bits: 0 normal, 1 swap, 2 duplicate A, 3 test ramp.
REQ-009 SHALL have port enable, input, 1 bit: request for soft un-mute (1) or soft mute (0).
REQ-010 SHALL have port m_axis_tdata, output, 32 bits: packed lanes; lane 0 in [15:0], lane 1 in [31:16].
REQ-011 SHALL have port m_axis_tvalid, output, 1 bit: output beat valid.
REQ-012 SHALL have port m_axis_tready, input, 1 bit: downstream accept.
REQ-013 SHALL have port ramp_state, output, 2 bits: 0 MUTED, 1 RAMP_UP, 2 ACTIVE, 3 RAMP_DOWN.

Function
REQ-014 SHALL define adv = !m_axis_tvalid || m_axis_tready; all pipeline, gain and counter registers SHALL update only when adv=1.
REQ-015 SHALL, in stage 1, compute ch+offset per lane at DW+1 bits and saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-016 SHALL apply lane routing in stage 1: mode 0 gives L0=A, L1=B; mode 1 gives L0=B, L1=A; mode 2 gives L0=L1=A; mode 3 gives L0=L1=test counter, with offset and saturation bypassed.
REQ-017 SHALL keep a DW-bit test counter that increments on each accepted beat (tvalid&&tready), wraps from 2^DW-1 to 0, and counts only while mode=3.
REQ-018 SHALL, in stage 2 (output register), form each lane as (sat*gain)>>>8, an arithmetic shift that floors toward minus infinity, with gain an unsigned 9-bit value in 0..256.
REQ-019 SHALL pack each lane as {(16-DW) zero bits, DW-bit result}.
REQ-020 SHALL provide 2 advancing cycles of latency from an input sampled with adv=1 to its appearance on m_axis_tdata.
REQ-021 SHALL raise m_axis_tvalid after 2 advancing cycles following reset release and keep it high thereafter.
REQ-022 SHALL hold m_axis_tdata stable while tvalid=1 and tready=0.
REQ-023 SHALL run the gain FSM as follows, with transitions evaluated only when adv=1:
  - MUTED: gain=0; enable=1 moves to RAMP_UP.
  - RAMP_UP: gain=min(gain+STEP,256); at 256 moves to ACTIVE; enable=0 moves to RAMP_DOWN from the current gain.
  - ACTIVE: gain=256; enable=0 moves to RAMP_DOWN.
  - RAMP_DOWN: gain=max(gain-STEP,0); at 0 moves to MUTED; enable=1 moves to RAMP_UP from the current gain.
REQ-024 SHALL use the gain value registered in the same cycle the stage-1 data is registered, so gain and data stay aligned in stage 2.
REQ-025 SHALL apply a mode change to samples entering stage 1 on that cycle only, with no flush of beats already in the pipe.
REQ-026 SHALL drive ramp_state from the FSM register.

Reset
REQ-027 SHALL, while rst=1, drive m_axis_tdata=0, m_axis_tvalid=0, gain=0, ramp_state=MUTED, test counter=0, and clear stage-1 registers.
REQ-028 SHALL, on rst asserted mid-ramp or mid-backpressure, discard held data and return to the REQ-027 state on the next clk edge after deassertion; there is no partial-beat recovery.

Verification
REQ-029 SHALL cover saturation: DW=14, gain=256, mode 0, ch_a=8000 with offset_a=500, and ch_b=-8000 with offset_b=-500 -> tdata[15:0]=0x1FFF, tdata[31:16]=0x2000.
REQ-030 SHALL cover ramp-up: STEP=64, tready=1, enable rising -> gain sequence 64,128,192,256 with ramp_state=ACTIVE after the 4th advancing cycle; ch_a=1000 gives lane 0 = 250,500,750,1000 in that order.
REQ-031 SHALL cover ramp reversal: enable dropped at gain=192 during RAMP_UP -> next gains 128,64,0, then ramp_state=MUTED; flooring shows ch_a=-1 at gain=128 -> lane 0 = 0x3FFF.
REQ-032 SHALL cover backpressure: tready held 0 for 5 cycles with inputs changing -> tdata, gain and ramp_state frozen; then tready=1 -> the next beats resume in order with none lost or duplicated.
REQ-033 SHALL cover test mode: mode=3, gain=256, tready toggling 1,0,1 -> both lanes count 0,1,2 only on accepted beats; counter 0x3FFF wraps to 0x0000.
REQ-034 SHALL cover reset: rst pulsed during RAMP_DOWN with tvalid=1 -> tvalid=0, tdata=0, ramp_state=MUTED immediately; tvalid returns high 2 cycles after release.
